sram_access_ctrl: RTL and testbench

Sequencer between the SLC-3 datapath's memory request side and the board's asynchronous 16-bit SRAM (or the simulation test memory on the same pins). Accepts one read or write request at a time via a valid/ready handshake, generates registered active-low CE/UB/LB/OE/WE strobes with a setup cycle, programmable access width and a hold cycle, and owns the bidirectional Data bus. Returns read data and a one-cycle completion pulse to the CPU.

---
 rtl/sram_access_ctrl_if.sv | 25 ++
 rtl/sram_access_ctrl.sv | 120 ++++++++++++
 tb/tb_sram_access_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// CPU-side request/response bundle for the SRAM access controller.
// The CPU uses the master view; the controller uses the slave view.
interface sram_access_ctrl_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// Single-request sequencer for an asynchronous 16-bit SRAM: setup, WAIT_CYCLES
// strobe, hold. All SRAM pins come from flops; Data is driven only for writes.
module sram_access_ctrl #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    sram_access_ctrl_if.slave   bus,
    output logic                CE,
    output logic                UB,
    output logic                LB,
    output logic                OE,
    output logic                WE,
    output logic [ADDR_W-1:0]   ADDR,
    inout  wire  [DATA_W-1:0]   Data
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("sram_access_ctrl: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              ce_n;
    logic              oe_n;
    logic              we_n;
    logic              drive;
    logic              we_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ce_n        <= 1'b1;
            oe_n        <= 1'b1;
            we_n        <= 1'b1;
            drive       <= 1'b0;
            we_q        <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        addr_q  <= bus.req_addr;
                        we_q    <= bus.req_we;
                        wdata_q <= bus.req_wdata;
                        ce_n    <= 1'b0;
                        // write data goes on the bus a full cycle before WE falls
                        drive   <= bus.req_we;
                        ready_q <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    cnt   <= CNT_INIT;
                    oe_n  <= we_q;
                    we_n  <= ~we_q;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!we_q) begin
                            rdata_q <= Data;
                        end
                        oe_n  <= 1'b1;
                        we_n  <= 1'b1;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    ce_n        <= 1'b1;
                    drive       <= 1'b0;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign CE   = ce_n;
    assign UB   = ce_n;
    assign LB   = ce_n;
    assign OE   = oe_n;
    assign WE   = we_n;
    assign ADDR = addr_q;
    assign Data = drive ? wdata_q : 'z;

    assign bus.req_ready = ready_q;
    assign bus.busy      = ~ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a small SRAM model that needs a
// full-length WE pulse to commit a write, plus a bus keeper pattern when CE=1.
module tb_sram_access_ctrl;

    localparam int unsigned AW   = 20;
    localparam int unsigned DW   = 16;
    localparam int unsigned WAIT = 2;
    localparam logic [DW-1:0] KEEP = 16'h5A5A;

    logic          Clk;
    logic          Reset;
    logic          CE, UB, LB, OE, WE;
    logic [AW-1:0] ADDR;
    wire  [DW-1:0] data_bus;

    int n_checks = 0;
    int n_errors = 0;

    sram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_access_ctrl #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .WAIT_CYCLES(WAIT)
    ) dut (
        .Clk (Clk),
        .Reset(Reset),
        .bus (bus),
        .CE  (CE),
        .UB  (UB),
        .LB  (LB),
        .OE  (OE),
        .WE  (WE),
        .ADDR(ADDR),
        .Data(data_bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SRAM model, 256 words indexed by ADDR[7:0]
    logic [DW-1:0] mem [0:255];
    assign data_bus = (!CE && !OE) ? mem[ADDR[7:0]] : 'z;
    assign data_bus = CE ? KEEP : 'z;

    initial begin
        int unsigned wlow;
        logic [7:0]  waddr;
        logic [DW-1:0] wdat;
        wlow = 0;
        waddr = '0;
        wdat = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h12] = 16'h1234;
        mem[8'h77] = 16'h1111;
        forever begin
            @(posedge Clk);
            if (!CE && !WE) begin
                wlow++;
                waddr = ADDR[7:0];
                wdat = data_bus;
            end else begin
                if (wlow >= WAIT) mem[waddr] = wdat;
                wlow = 0;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tick();
        bus.req_valid = 1'b0;
        chk("setup_ce", 32'(CE), 32'd0);
        chk("setup_oe_we", 32'({OE, WE}), 32'b11);
        chk("setup_addr", 32'(ADDR), 32'(addr));
        chk("setup_busy", 32'({bus.req_ready, bus.busy}), 32'b01);
        if (we) chk("setup_data", 32'(data_bus), 32'(wdata));
        tick();
        for (int k = 0; k < int'(WAIT); k++) begin
            chk("access_ce", 32'(CE), 32'd0);
            chk("access_oe", 32'(OE), 32'(we));
            chk("access_we", 32'(WE), 32'(!we));
            if (we) chk("access_data", 32'(data_bus), 32'(wdata));
            tick();
        end
        chk("hold_strobes", 32'({CE, OE, WE}), 32'b011);
        chk("hold_rsp", 32'(bus.rsp_valid), 32'd0);
        if (we) chk("hold_data", 32'(data_bus), 32'(wdata));
        tick();
        chk("done_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("done_ce", 32'({CE, UB, LB}), 32'b111);
        chk("done_ready", 32'(bus.req_ready), 32'd1);
        chk("done_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        chk("done_bus_released", 32'(data_bus), 32'(KEEP));
        tick();
        chk("pulse_end", 32'(bus.rsp_valid), 32'd0);
        chk("addr_retained", 32'(ADDR), 32'(addr));
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int pulses, first, second;

        vecs[0] = '{we: 1'b0, addr: 20'h00012, wdata: 16'h0000, exp_rdata: 16'h1234};
        vecs[1] = '{we: 1'b1, addr: 20'h0ABCD, wdata: 16'hBEEF, exp_rdata: 16'h1234};
        vecs[2] = '{we: 1'b0, addr: 20'h0ABCD, wdata: 16'h0000, exp_rdata: 16'hBEEF};
        vecs[3] = '{we: 1'b1, addr: 20'h00001, wdata: 16'h0101, exp_rdata: 16'hBEEF};
        vecs[4] = '{we: 1'b1, addr: 20'h00002, wdata: 16'h0202, exp_rdata: 16'hBEEF};
        vecs[5] = '{we: 1'b0, addr: 20'h00001, wdata: 16'h0000, exp_rdata: 16'h0101};

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        Reset = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        chk("rst_strobes", 32'({CE, UB, LB, OE, WE}), 32'b11111);
        chk("rst_addr", 32'(ADDR), 32'd0);
        chk("rst_data_z", 32'(data_bus), 32'(KEEP));
        chk("rst_ready", 32'({bus.req_ready, bus.busy, bus.rsp_valid}), 32'b100);
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        tick();
        chk("idle_no_req", 32'({CE, bus.req_ready}), 32'b11);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
        end

        // back-to-back reads with req_valid held high
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 20'h00001;
        tick();
        bus.req_addr = 20'h00002;
        pulses = 0;
        first  = 0;
        second = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 5) begin
                bus.req_valid = 1'b0;
                chk("b2b_second_addr", 32'(ADDR), 32'h00002);
                chk("b2b_second_accept", 32'(bus.req_ready), 32'd0);
            end
            if (bus.rsp_valid) begin
                pulses++;
                if (pulses == 1) begin
                    first = c;
                    chk("b2b_first_rdata", 32'(bus.rsp_rdata), 32'h0101);
                    chk("b2b_ready_in_pulse", 32'(bus.req_ready), 32'd1);
                end else begin
                    second = c;
                end
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_first_at", 32'(first), 32'd4);
        chk("b2b_second_at", 32'(second), 32'd9);
        chk("b2b_second_rdata", 32'(bus.rsp_rdata), 32'h0202);

        // request raised during ACCESS is ignored
        bus.req_valid = 1'b1;
        bus.req_addr  = 20'h00012;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.req_valid = 1'b1;
        bus.req_addr  = 20'h00055;
        tick();
        bus.req_valid = 1'b0;
        chk("ign_addr", 32'(ADDR), 32'h00012);
        pulses = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.rsp_valid) pulses++;
        end
        chk("ign_pulses", 32'(pulses), 32'd1);
        chk("ign_rdata", 32'(bus.rsp_rdata), 32'h1234);
        chk("ign_addr_end", 32'(ADDR), 32'h00012);

        // reset during the first ACCESS cycle of a write
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 20'h00077;
        bus.req_wdata = 16'hCAFE;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("abort_we_low", 32'(WE), 32'd0);
        Reset = 1'b0;
        tick();
        chk("abort_strobes", 32'({CE, WE, OE}), 32'b111);
        chk("abort_data_z", 32'(data_bus), 32'(KEEP));
        chk("abort_rsp", 32'(bus.rsp_valid), 32'd0);
        Reset = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (bus.rsp_valid) pulses++;
        end
        chk("abort_no_rsp", 32'(pulses), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        bus.req_we = 1'b0;
        run_txn(1'b0, 20'h00077, 16'h0000, 16'h1111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1, "timeout");
    end

endmodule
